// File: rtl/layer2_window_scheduler_pkg.sv
// Layer-2 window scheduler shared types: FSM state, frame geometry
// defaults and the window descriptor bundle.
package layer2_window_scheduler_pkg;

   localparam int DEF_WIDTH     = 13;
   localparam int DEF_HEIGHT    = 17;
   localparam int DEF_CH_GROUPS = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [4:0] row;
      logic [3:0] col;
      logic [1:0] grp;
      logic       first;
      logic       last;
   } win_desc_t;

endpackage

// File: rtl/layer2_window_scheduler_if.sv
// Window descriptor valid/ready channel to the conv engine.
// master: scheduler (drives valid + fields), slave: conv engine (drives ready).
interface layer2_window_scheduler_if;

   logic       win_valid;
   logic       win_ready;
   logic [4:0] win_row;
   logic [3:0] win_col;
   logic [1:0] win_grp;
   logic       win_first;
   logic       win_last;

   modport master (
      output win_valid, win_row, win_col, win_grp,
      output win_first, win_last,
      input  win_ready
   );

   modport slave (
      input  win_valid, win_row, win_col, win_grp,
      input  win_first, win_last,
      output win_ready
   );

endinterface

// File: rtl/layer2_window_scheduler_window_counter.sv
// Nested row/col/grp window counter (grp fastest).
// clr: load zero, inc: advance; wrap[0..2]: grp/col/row wrap strobes; first/last flags.
module window_counter
   import layer2_window_scheduler_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int HEIGHT    = DEF_HEIGHT,
   parameter int CH_GROUPS = DEF_CH_GROUPS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [4:0] row,
   output logic [3:0] col,
   output logic [1:0] grp,
   output logic [2:0] wrap,
   output logic       first,
   output logic       last
);

   logic grp_max, col_max, row_max;

   assign grp_max = (grp == 2'(CH_GROUPS - 1));
   assign col_max = (col == 4'(WIDTH - 1));
   assign row_max = (row == 5'(HEIGHT - 1));

   // wrap strobes cascade like carries; wrap[2] marks the frame wrap
   assign wrap[0] = inc & grp_max;
   assign wrap[1] = wrap[0] & col_max;
   assign wrap[2] = wrap[1] & row_max;

   assign first = (row == 5'd0) & (col == 4'd0) & (grp == 2'd0);
   assign last  = row_max & col_max & grp_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
         grp <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
         grp <= '0;
      end else if (inc) begin
         grp <= wrap[0] ? 2'd0 : grp + 2'd1;
         if (wrap[0])
            col <= wrap[1] ? 4'd0 : col + 4'd1;
         if (wrap[1])
            row <= wrap[2] ? 5'd0 : row + 5'd1;
      end
   end

endmodule

// File: rtl/layer2_window_scheduler.sv
// Ping-pong bank tracker plus 3x3 window descriptor issue for layer 2.
// Ports: clk, rst_n, fill_done in; wr_bank/wr_ok/rd_bank/frame_done/overflow out; win (master).
module layer2_window_scheduler
   import layer2_window_scheduler_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int HEIGHT    = DEF_HEIGHT,
   parameter int CH_GROUPS = DEF_CH_GROUPS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic fill_done,
   output logic wr_bank,
   output logic wr_ok,
   output logic rd_bank,
   output logic frame_done,
   output logic overflow,
   layer2_window_scheduler_if.master win
);

   state_t     state, state_nxt;
   logic [1:0] full, full_nxt;
   logic       valid, valid_nxt;
   logic       load, accept, fill, frame_end;
   logic [4:0] c_row;
   logic [3:0] c_col;
   logic [1:0] c_grp;
   logic [2:0] c_wrap;
   logic       c_first, c_last;
   win_desc_t  desc;

   window_counter #(
      .WIDTH     (WIDTH),
      .HEIGHT    (HEIGHT),
      .CH_GROUPS (CH_GROUPS)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load),
      .inc   (accept),
      .row   (c_row),
      .col   (c_col),
      .grp   (c_grp),
      .wrap  (c_wrap),
      .first (c_first),
      .last  (c_last)
   );

   assign desc = {c_row, c_col, c_grp, c_first, c_last};

   assign wr_ok     = !full[wr_bank];
   assign fill      = fill_done & wr_ok;
   assign accept    = valid & win.win_ready;
   // all counter levels wrapping together is the last-window acceptance
   assign frame_end = &c_wrap;

   assign win.win_valid = valid;
   assign win.win_row   = desc.row;
   assign win.win_col   = desc.col;
   assign win.win_grp   = desc.grp;
   assign win.win_first = valid & desc.first;
   assign win.win_last  = valid & desc.last;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      valid_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (frame_end)
               state_nxt = IDLE;
            else
               valid_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // release and fill always hit different banks, so both can apply
   always_comb begin
      full_nxt = full;
      if (frame_end)
         full_nxt[rd_bank] = 1'b0;
      if (fill)
         full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         full       <= 2'b00;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         full       <= full_nxt;
         valid      <= valid_nxt;
         frame_done <= frame_end;
         if (fill)
            wr_bank <= ~wr_bank;
         if (frame_end)
            rd_bank <= ~rd_bank;
         if (fill_done & !wr_ok)
            overflow <= 1'b1;
      end
   end

endmodule

// File: doc/layer2_window_scheduler.md
LAYER2_WINDOW_SCHEDULER -- requirements
Module: layer2_window_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 13, feature-map columns.
REQ-002 SHALL have parameter HEIGHT, default 17, feature-map rows.
REQ-003 SHALL have parameter CH_GROUPS, default 4, channel groups per position (32 channels / 8 lanes).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fill_done  input  1  one-cycle pulse from the input buffer: the current write bank is completely filled.
REQ-007 win_ready  input  1  conv engine accepts the presented window.
REQ-008 wr_bank  output  1  bank the input buffer writes next.
REQ-009 wr_ok  output  1  high when bank wr_bank is free to fill.
REQ-010 rd_bank  output  1  bank the conv engine reads.
REQ-011 win_valid  output  1  window descriptor valid.
REQ-012 win_row  output  5  centre row of the 3x3 window, 0..HEIGHT-1.
REQ-013 win_col  output  4  centre column, 0..WIDTH-1.
REQ-014 win_grp  output  2  channel group, 0..CH_GROUPS-1.
REQ-015 win_first / win_last  output  1 each  descriptor is the first / last of the frame.
REQ-016 frame_done  output  1  one-cycle pulse after the last descriptor is accepted.
REQ-017 overflow  output  1  sticky error flag.

Function
REQ-018 SHALL track two banks with flags full[1:0]; wr_ok = !full[wr_bank].
REQ-019 When fill_done=1 and wr_ok=1: set full[wr_bank] and toggle wr_bank on the same edge.
REQ-020 When fill_done=1 and wr_ok=0: ignore the pulse, leave full/wr_bank unchanged, and set overflow (cleared only by reset).
REQ-021 FSM states IDLE, RUN. IDLE->RUN when full[rd_bank]=1. RUN->IDLE on acceptance of the win_last descriptor.
REQ-022 On IDLE->RUN, counters SHALL load row=0, col=0, grp=0, and win_valid SHALL rise on the following cycle (latency 1 from the edge that sets full[rd_bank] to RUN entry, +1 to win_valid).
REQ-023 Handshake: a descriptor is accepted when win_valid & win_ready; while win_valid=1 and win_ready=0, all win_* outputs SHALL hold stable.
REQ-024 Order on acceptance: grp increments fastest; at CH_GROUPS-1 it wraps to 0 and col increments; at WIDTH-1 col wraps to 0 and row increments; 884 descriptors per frame at defaults.
REQ-025 win_first=1 only at (0,0,0); win_last=1 only at (HEIGHT-1, WIDTH-1, CH_GROUPS-1).
REQ-026 On acceptance of win_last: clear full[rd_bank], toggle rd_bank, drop win_valid, and pulse frame_done on the next cycle.
REQ-027 If the other bank is already full at frame end, SHALL pass through IDLE for exactly one cycle and restart; no descriptor may be skipped or duplicated.
REQ-028 fill_done on the same edge as the REQ-026 release SHALL apply both updates; the bank freed by the release becomes writable on the following cycle.
REQ-029 Back-to-back acceptance (win_ready held high) SHALL sustain one descriptor per cycle.

Reset
REQ-030 While rst_n=0: full=2'b00, wr_bank=0, rd_bank=0, state=IDLE, counters=0, win_valid=0, win_first=0, win_last=0, frame_done=0, overflow=0, all win_* fields=0.
REQ-031 Reset asserted mid-frame SHALL abort immediately; no frame_done is issued for the aborted frame.

Structure
REQ-032 The shared layer-2 package SHALL hold the FSM state enum, the WIDTH/HEIGHT/CH_GROUPS defaults, and the descriptor struct (row, col, grp, first, last).
REQ-033 The row/col/grp nested counter SHALL be a sub-module window_counter with inc input, wrap outputs, and first/last flags.

Verification
REQ-034 Reset, then one fill_done, then win_ready=1 -> descriptors appear one cycle after RUN entry; 884 accepted in order; frame_done pulses once; rd_bank=1 and full=00.
REQ-035 win_ready toggled pseudo-randomly -> outputs stable during stalls; sequence identical to REQ-034.
REQ-036 Two fill_done pulses 5 cycles apart -> full=11, wr_ok=0; a third pulse sets overflow=1 and leaves full unchanged; the two frames run back-to-back with a one-cycle IDLE gap.
REQ-037 fill_done on the same edge as the frame-0 last acceptance -> full and bank pointers are correct; frame 1 starts without loss.
REQ-038 rst_n pulsed low at descriptor 400 -> all outputs match REQ-030 immediately; no frame_done occurs.
